// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war LED decoder: pattern codes, FSM states,
// signed rope position and the pattern classifier.
package tow_pkg;

    // LED pattern codes as driven by the encoder (bit 6 = leftmost LED)
    localparam logic [6:0] PatL3      = 7'b1000000;
    localparam logic [6:0] PatL2      = 7'b0100000;
    localparam logic [6:0] PatL1      = 7'b0010000;
    localparam logic [6:0] PatN       = 7'b0001000;
    localparam logic [6:0] PatR1      = 7'b0000100;
    localparam logic [6:0] PatR2      = 7'b0000010;
    localparam logic [6:0] PatR3      = 7'b0000001;
    localparam logic [6:0] PatLwin    = 7'b1110000;
    localparam logic [6:0] PatRwin    = 7'b0000111;
    localparam logic [6:0] PatRstDisp = 7'b1100011;
    localparam logic [6:0] PatBlank   = 7'b0000000;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StWin
    } tow_state_e;

    // -3 = L3, 0 = N, +3 = R3
    typedef logic signed [2:0] tow_pos_t;

    localparam tow_pos_t PosL3 = -3'sd3;
    localparam tow_pos_t PosR3 = 3'sd3;

    typedef enum logic [2:0] {
        KindPos,
        KindLwin,
        KindRwin,
        KindRstDisp,
        KindBlank,
        KindUnknown
    } tow_kind_e;

    typedef struct packed {
        tow_kind_e kind;
        tow_pos_t  pos;
    } tow_decode_t;

    // Classify a raw LED pattern; pos is only meaningful for KindPos
    function automatic tow_decode_t tow_decode(input logic [6:0] pat);
        tow_decode_t d;
        d.kind = KindUnknown;
        d.pos  = '0;
        case (pat)
            PatL3:      begin d.kind = KindPos; d.pos = -3'sd3; end
            PatL2:      begin d.kind = KindPos; d.pos = -3'sd2; end
            PatL1:      begin d.kind = KindPos; d.pos = -3'sd1; end
            PatN:       begin d.kind = KindPos; d.pos = 3'sd0;  end
            PatR1:      begin d.kind = KindPos; d.pos = 3'sd1;  end
            PatR2:      begin d.kind = KindPos; d.pos = 3'sd2;  end
            PatR3:      begin d.kind = KindPos; d.pos = 3'sd3;  end
            PatLwin:    d.kind = KindLwin;
            PatRwin:    d.kind = KindRwin;
            PatRstDisp: d.kind = KindRstDisp;
            PatBlank:   d.kind = KindBlank;
            default:    d.kind = KindUnknown;
        endcase
        return d;
    endfunction

    // True when moving from a to b skips more than one LED
    function automatic logic tow_is_jump(input tow_pos_t a, input tow_pos_t b);
        logic signed [3:0] diff;
        diff = {b[2], b} - {a[2], a};
        return (diff > 4'sd1) || (diff < -4'sd1);
    endfunction

endpackage

// File: rtl/tow_stable_filter.sv
// Stability filter: a pattern must be seen on STABLE_CNT consecutive sample
// ticks before it is accepted. Acceptance is a one-shot strobe, combinational
// on the accepting tick so the consumer registers its result on that edge.
module tow_stable_filter #(
    parameter int unsigned STABLE_CNT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic [6:0] leds_in,
    output logic       accept,
    output logic [6:0] pattern
);

    localparam int unsigned StableCnt = (STABLE_CNT < 1) ? 1 : STABLE_CNT;
    localparam int unsigned CntW      = $clog2(StableCnt + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(StableCnt);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [6:0]      cand_q, cand_d;
    logic [CntW-1:0] count_q, count_d;

    // Candidate/count update; counter saturates at CntMax so a held pattern
    // reaches the threshold exactly once
    always_comb begin
        cand_d  = cand_q;
        count_d = count_q;
        accept  = 1'b0;
        if (sample_en) begin
            if (leds_in == cand_q) begin
                if (count_q < CntMax) begin
                    count_d = count_q + CntOne;
                    accept  = ((count_q + CntOne) == CntMax);
                end
            end else begin
                cand_d  = leds_in;
                count_d = CntOne;
                accept  = (CntMax == CntOne);
            end
        end
    end

    // Filter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q  <= '0;
            count_q <= '0;
        end else begin
            cand_q  <= cand_d;
            count_q <= count_d;
        end
    end

    assign pattern = leds_in;

endmodule

// File: rtl/tow_led_decoder.sv
// Tug-of-war LED decoder: filters the observed LED pattern, tracks the rope
// position and round state, pulses on wins and keeps per-player scores.
// Optional macro TOW_MOVE_CHECK_EN enables the sticky move-legality flag;
// without it `illegal` is tied low.
module tow_led_decoder
    import tow_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 2,
    parameter int unsigned SCORE_W    = 4
) (
    input  logic               CLK_I,
    input  logic               rst,
    input  logic               sample_en,
    input  logic [6:0]         leds_in,
    output logic [2:0]         pos,
    output logic               pos_valid,
    output logic               round_active,
    output logic               win_left,
    output logic               win_right,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               illegal
);

    logic        accept;
    logic [6:0]  acc_pat;
    tow_decode_t dec;

    tow_stable_filter #(
        .STABLE_CNT (STABLE_CNT)
    ) u_filter (
        .clk       (CLK_I),
        .rst       (rst),
        .sample_en (sample_en),
        .leds_in   (leds_in),
        .accept    (accept),
        .pattern   (acc_pat)
    );

    assign dec = tow_decode(acc_pat);

    tow_state_e         state_q, state_d;
    tow_pos_t           pos_q, pos_d;
    logic               pos_valid_q, pos_valid_d;
    logic               win_left_q, win_left_d;
    logic               win_right_q, win_right_d;
    logic [SCORE_W-1:0] score_left_q, score_left_d;
    logic [SCORE_W-1:0] score_right_q, score_right_d;
    logic               viol;
    logic               clear_ill;

    // Next-state, position, score and violation decode for an accepted pattern
    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        pos_valid_d   = pos_valid_q;
        win_left_d    = 1'b0;
        win_right_d   = 1'b0;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        viol          = 1'b0;
        clear_ill     = 1'b0;
        if (accept) begin
            case (dec.kind)
                KindRstDisp: begin
                    state_d       = StIdle;
                    pos_d         = '0;
                    pos_valid_d   = 1'b0;
                    score_left_d  = '0;
                    score_right_d = '0;
                    clear_ill     = 1'b1;
                end
                KindPos: begin
                    state_d     = StPlay;
                    pos_d       = dec.pos;
                    pos_valid_d = 1'b1;
                    // A round must open at N; during play only single steps
                    if (state_q == StPlay) begin
                        viol = tow_is_jump(pos_q, dec.pos);
                    end else begin
                        viol = (dec.pos != 3'sd0);
                    end
                end
                KindLwin: begin
                    if (state_q == StIdle) begin
                        viol = 1'b1;
                    end else if (state_q == StPlay) begin
                        state_d      = StWin;
                        win_left_d   = 1'b1;
                        score_left_d = (score_left_q == '1) ? score_left_q
                                                            : score_left_q + 1'b1;
                        viol         = (pos_q != PosL3);
                    end
                end
                KindRwin: begin
                    if (state_q == StIdle) begin
                        viol = 1'b1;
                    end else if (state_q == StPlay) begin
                        state_d       = StWin;
                        win_right_d   = 1'b1;
                        score_right_d = (score_right_q == '1) ? score_right_q
                                                              : score_right_q + 1'b1;
                        viol          = (pos_q != PosR3);
                    end
                end
                KindBlank: begin
                end
                default: begin
                    viol = 1'b1;
                end
            endcase
        end
    end

    // Main state register; rst overrides any acceptance on the same edge
    always_ff @(posedge CLK_I) begin
        if (rst) begin
            state_q       <= StIdle;
            pos_q         <= '0;
            pos_valid_q   <= 1'b0;
            win_left_q    <= 1'b0;
            win_right_q   <= 1'b0;
            score_left_q  <= '0;
            score_right_q <= '0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            pos_valid_q   <= pos_valid_d;
            win_left_q    <= win_left_d;
            win_right_q   <= win_right_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
        end
    end

`ifdef TOW_MOVE_CHECK_EN
    logic illegal_q;

    // Sticky violation flag, cleared only by rst or an accepted RSTDISP
    always_ff @(posedge CLK_I) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (clear_ill) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_q | viol;
        end
    end

    assign illegal = illegal_q;
`else
    logic unused_chk;
    assign unused_chk = viol ^ clear_ill;
    assign illegal    = 1'b0;
`endif

    assign pos          = pos_q;
    assign pos_valid    = pos_valid_q;
    assign round_active = (state_q == StPlay);
    assign win_left     = win_left_q;
    assign win_right    = win_right_q;
    assign score_left   = score_left_q;
    assign score_right  = score_right_q;

endmodule
